switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop depth per switch bit, legal range 2..4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000 (10 ms at 10 MHz): consecutive stable samples required before a value is accepted, legal range 1..2^20.
REQ-003 Parameter VALID_CYCLES, default 1: number of cycles valid is held high per accepted change, legal range 1..255.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 rawSwitch  input  2  asynchronous board switch levels.
REQ-007 debSwitch  output  2  debounced, committed switch value; feeds the downstream LED block's inSwitch.
REQ-008 valid  output  1  high while a newly committed debSwitch is being presented; feeds the downstream LED block's valid.
REQ-009 busy  output  1  high in SETTLE or EMIT.

Function
REQ-010 rawSwitch SHALL pass through a SYNC_STAGES-deep flop chain per bit; only the last stage ("synced") is used by any other logic.
REQ-011 The FSM SHALL have exactly three states: IDLE, SETTLE, EMIT.
REQ-012 IDLE: when synced != debSwitch, go to SETTLE, latch candidate = synced, load count = 1; otherwise stay in IDLE.
REQ-013 SETTLE, synced == candidate: increment count; when count reaches DEBOUNCE_CYCLES, go to EMIT and set debSwitch = candidate in the same edge.
REQ-014 SETTLE, synced != candidate and != debSwitch: re-latch candidate = synced, count = 1, stay in SETTLE.
REQ-015 SETTLE, synced == debSwitch: go to IDLE and clear count; valid is not asserted.
REQ-016 EMIT: valid = 1 for exactly VALID_CYCLES cycles, then go to IDLE; debSwitch is stable throughout EMIT.
REQ-017 Input changes during EMIT SHALL be ignored until IDLE, then re-evaluated per REQ-012; no changes are queued.
REQ-018 Latency: if rawSwitch changes once and stays stable, valid SHALL rise SYNC_STAGES + DEBOUNCE_CYCLES cycles after the first clock edge that samples the new value.
REQ-019 valid and busy SHALL be registered outputs; debSwitch SHALL change only on entry to EMIT.
REQ-020 The count register width SHALL be $clog2(DEBOUNCE_CYCLES+1); the count SHALL saturate and never wrap.
REQ-021 With DEBOUNCE_CYCLES = 1, a change stable for one synced sample SHALL be accepted.

Reset
REQ-022 While rst = 1: state = IDLE, debSwitch = 2'b00, valid = 0, busy = 0, count = 0, candidate = 2'b00, all synchronizer flops = 0.
REQ-023 rst asserted mid-SETTLE or mid-EMIT SHALL abort the operation with no further valid pulse, taking effect at the next clock edge.
REQ-024 A nonzero rawSwitch held through reset release SHALL be debounced and emitted as a normal change from 2'b00.

Structure
REQ-025 Package switch_debounce_pkg SHALL hold the state enum (IDLE, SETTLE, EMIT) and the default parameter constants.
REQ-026 The synchronizer SHALL be one sub-module, bit_synchronizer (parameterized depth and width), instantiated once for 2 bits.
REQ-027 The FSM, counter, and output registers SHALL live in switch_debounce; there are no other sub-modules.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=8, VALID_CYCLES=10, clk 100 ns)
REQ-028 Hold rawSwitch = 01 through reset release -> valid high 10 cycles with debSwitch = 01, rising 10 cycles after the first sampling edge.
REQ-029 Apply 10 then toggle 10/00 every 3 cycles for 40 cycles, then hold 10 -> no valid during bounce; one valid with debSwitch = 10 arrives 10 cycles after the final change.
REQ-030 From debSwitch = 10, pulse rawSwitch to 11 for 5 cycles and back to 10 -> busy high during the glitch, no valid, debSwitch stays 10.
REQ-031 Change 11 -> 00 in the 3rd cycle of EMIT -> the current valid completes 10 cycles unchanged, then SETTLE and a second valid with debSwitch = 00.
REQ-032 Assert rst for 1 cycle at count = 5 in SETTLE -> next edge: all outputs 0, state IDLE, no valid for the aborted candidate.
REQ-033 Run the sequence 01, 10, 11, 00, each held 30 cycles -> four valid pulses in order with matching debSwitch, and busy low between them.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Shared types and default constants for the two-bit switch debouncer.
// The FSM state enum lives here so the bench and RTL agree on the names.
package switch_debounce_pkg;

  localparam int SW_WIDTH            = 2;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 100000;
  localparam int DEF_VALID_CYCLES    = 1;
  localparam int VCNT_WIDTH          = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EMIT   = 2'd2
  } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a bus of independent asynchronous bits.
// Each bit passes through DEPTH flops; only the last stage leaves the module.
module bit_synchronizer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], i_async};
    end
  end

  assign o_sync = r_stage[DEPTH-1];

endmodule

// File: rtl/switch_debounce.sv
// Debounces a two-bit switch: a new synced value must hold for DEBOUNCE_CYCLES
// samples before it is committed and announced with a VALID_CYCLES-long pulse.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int VALID_CYCLES    = DEF_VALID_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] rawSwitch,
  output logic [SW_WIDTH-1:0] debSwitch,
  output logic                valid,
  output logic                busy
);

  localparam int                    CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]         CNT_TARGET = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [VCNT_WIDTH-1:0] VCNT_LOAD  = VCNT_WIDTH'(VALID_CYCLES - 1);

  logic [SW_WIDTH-1:0]   w_synced;
  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_count, w_count_next;
  logic [SW_WIDTH-1:0]   r_cand, w_cand_next;
  logic [SW_WIDTH-1:0]   r_deb, w_deb_next;
  logic [VCNT_WIDTH-1:0] r_vcnt, w_vcnt_next;
  logic                  r_valid, w_valid_next;
  logic                  r_busy, w_busy_next;

  bit_synchronizer #(
    .DEPTH (SYNC_STAGES),
    .WIDTH (SW_WIDTH)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rawSwitch),
    .o_sync  (w_synced)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_cand  <= '0;
      r_deb   <= '0;
      r_vcnt  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_cand  <= w_cand_next;
      r_deb   <= w_deb_next;
      r_vcnt  <= w_vcnt_next;
      r_valid <= w_valid_next;
      r_busy  <= w_busy_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_cand_next  = r_cand;
    w_deb_next   = r_deb;
    w_vcnt_next  = r_vcnt;
    unique case (r_state)
      IDLE: begin
        if (w_synced != r_deb) begin
          w_state_next = SETTLE;
          w_cand_next  = w_synced;
          w_count_next = CNT_ONE;
        end
      end
      SETTLE: begin
        if (w_synced == r_cand) begin
          // Only increment below the target so the counter saturates.
          if (r_count >= CNT_TARGET) begin
            w_state_next = EMIT;
            w_deb_next   = r_cand;
            w_vcnt_next  = VCNT_LOAD;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CNT_ONE;
          end
        end else if (w_synced == r_deb) begin
          w_state_next = IDLE;
          w_count_next = '0;
        end else begin
          w_cand_next  = w_synced;
          w_count_next = CNT_ONE;
        end
      end
      EMIT: begin
        if (r_vcnt == '0) begin
          w_state_next = IDLE;
        end else begin
          w_vcnt_next = r_vcnt - 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_valid_next = (w_state_next == EMIT);
    w_busy_next  = (w_state_next != IDLE);
  end

  assign debSwitch = r_deb;
  assign valid     = r_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios, a vector table and a random
// phase, all compared cycle by cycle against a behavioural debounce model.
module tb_switch_debounce;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int VAL  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rawSwitch = 2'b01;
  logic [1:0] debSwitch, deb1;
  logic       valid, busy, valid1, busy1;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  switch_debounce #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .VALID_CYCLES    (VAL)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .rawSwitch (rawSwitch),
    .debSwitch (debSwitch),
    .valid     (valid),
    .busy      (busy)
  );

  // Minimum-debounce instance with a deeper synchronizer.
  switch_debounce #(
    .SYNC_STAGES     (3),
    .DEBOUNCE_CYCLES (1),
    .VALID_CYCLES    (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .rawSwitch (rawSwitch),
    .debSwitch (deb1),
    .valid     (valid1),
    .busy      (busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 50)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Behavioural model: a sample delay line plus "committed / candidate with
  // run length / remaining announce time" bookkeeping.
  logic [1:0] sync_q[$];
  logic [1:0] m_deb = 2'b00, m_cand = 2'b00;
  int         m_cnt = 0, m_emit = 0;
  bit         m_settling = 0, m_ready = 0;

  always @(posedge clk) begin
    logic [1:0] s;
    if (rst) begin
      sync_q.delete();
      for (int k = 0; k < SYNC; k++) sync_q.push_back(2'b00);
      m_deb = 2'b00; m_cand = 2'b00; m_cnt = 0; m_emit = 0;
      m_settling = 0; m_ready = 1;
    end else begin
      s = sync_q.pop_front();
      sync_q.push_back(rawSwitch);
      if (m_emit > 0) begin
        m_emit--;
      end else if (!m_settling) begin
        if (s != m_deb) begin
          m_settling = 1; m_cand = s; m_cnt = 1;
        end
      end else if (s == m_cand) begin
        if (m_cnt >= DEB) begin
          m_deb = m_cand; m_emit = VAL; m_settling = 0;
        end else begin
          m_cnt++;
        end
      end else if (s == m_deb) begin
        m_settling = 0;
      end else begin
        m_cand = s; m_cnt = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("model_deb",   debSwitch, m_deb);
      check("model_valid", valid,     m_emit > 0);
      check("model_busy",  busy,      m_settling || (m_emit > 0));
    end
  end

  typedef struct {
    logic [1:0] raw;
    int         hold;
    logic [1:0] exp_deb;
    int         exp_valid_cycles;
    logic       exp_busy_end;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, cnt_v, seen_busy;
    bit ok;

    tbl[0] = '{2'b01, 30, 2'b01, VAL, 1'b0};
    tbl[1] = '{2'b10, 30, 2'b10, VAL, 1'b0};
    tbl[2] = '{2'b11, 30, 2'b11, VAL, 1'b0};
    tbl[3] = '{2'b00, 30, 2'b00, VAL, 1'b0};

    // Reset state with 01 held on the switch.
    cyc(3);
    check("reset_deb", debSwitch, 2'b00);
    check("reset_valid", valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_valid1", valid1, 1'b0);

    // 01 held through reset release.
    rst = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      cyc(1);
      check("rel_valid_latency", valid, (i == 10));
      check("d1_valid_latency", valid1, (i == 4));
      if (i == 4) check("d1_deb", deb1, 2'b01);
    end
    check("rel_deb", debSwitch, 2'b01);
    n = 1;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      if (valid) n++;
    end
    check("rel_valid_len", n, VAL);

    // Bounce between 10 and 00, then settle on 10.
    cnt_v = 0;
    for (int i = 0; i < 40; i++) begin
      rawSwitch = (((i / 3) % 2) == 0) ? 2'b10 : 2'b00;
      cyc(1);
      if (valid) cnt_v++;
    end
    check("bounce_no_valid", cnt_v, 0);
    rawSwitch = 2'b10;
    for (int i = 0; i <= 10; i++) begin
      cyc(1);
      if (i >= 9) check("bounce_final_latency", valid, (i == 10));
    end
    check("bounce_deb", debSwitch, 2'b10);
    cyc(15);

    // Short glitch to 11.
    seen_busy = 0; cnt_v = 0;
    rawSwitch = 2'b11;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      if (busy) seen_busy = 1;
      if (valid) cnt_v++;
    end
    rawSwitch = 2'b10;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      if (busy) seen_busy = 1;
      if (valid) cnt_v++;
    end
    check("glitch_busy_seen", seen_busy, 1);
    check("glitch_no_valid", cnt_v, 0);
    check("glitch_deb", debSwitch, 2'b10);
    check("glitch_busy_end", busy, 1'b0);

    // Input change in the 3rd cycle of EMIT.
    rawSwitch = 2'b11;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (valid) break;
    end
    check("emit_rise", valid, 1'b1);
    n = 1;
    cyc(1);
    if (valid) n++;
    rawSwitch = 2'b00;
    ok = 1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (valid) begin
        n++;
        if (debSwitch != 2'b11) ok = 0;
      end else break;
    end
    check("emit_len", n, VAL);
    check("emit_deb_stable", ok, 1'b1);
    for (int k = 0; k < 30; k++) begin
      cyc(1);
      if (valid) break;
    end
    check("emit_second_valid", valid, 1'b1);
    check("emit_second_deb", debSwitch, 2'b00);
    cyc(15);

    // Reset at count = 5 during SETTLE.
    rawSwitch = 2'b01;
    cyc(7);
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    rawSwitch = 2'b00;
    cyc(1);
    check("abort_deb", debSwitch, 2'b00);
    check("abort_valid", valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    rst = 1'b0;
    cnt_v = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      if (valid) cnt_v++;
    end
    check("abort_no_valid", cnt_v, 0);

    // Vector table: 01, 10, 11, 00 each held 30 cycles.
    foreach (tbl[t]) begin
      rawSwitch = tbl[t].raw;
      cnt_v = 0; ok = 1;
      for (int k = 0; k < tbl[t].hold; k++) begin
        cyc(1);
        if (valid) begin
          cnt_v++;
          if (debSwitch != tbl[t].exp_deb) ok = 0;
        end
      end
      check("tbl_valid_cycles", cnt_v, tbl[t].exp_valid_cycles);
      check("tbl_deb_during_valid", ok, 1'b1);
      check("tbl_deb_end", debSwitch, tbl[t].exp_deb);
      check("tbl_busy_end", busy, tbl[t].exp_busy_end);
    end

    // Random phase checked only by the model.
    for (int seg = 0; seg < 200; seg++) begin
      rawSwitch = 2'($urandom_range(3, 0));
      if ($urandom_range(39, 0) == 0) begin
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
      end
      cyc($urandom_range(14, 1));
    end
    rawSwitch = 2'b00;
    cyc(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
